// File: rtl/abs_value_ieee754.sv
// abs_value_ieee754
// Single-cycle registered sign manipulation of an IEEE-754 single-precision
// operand (abs / negate / negative-abs / pass-through), plus classification
// flags for the input operand. Pure bit manipulation: no rounding, no
// exceptions.
//
// Parameters
//   CANON_NAN    : 1 replaces every NaN result with the quiet NaN 32'h7FC00000
// Ports
//   clk          : clock, all state updates on rising edge
//   rst          : synchronous active-high reset
//   in_valid     : data_in / op valid this cycle
//   data_in      : IEEE-754 single-precision operand
//   op           : 00 abs, 01 negate, 10 negative-abs, 11 pass-through
//   out_valid    : registered in_valid (no backpressure)
//   data_out     : result word
//   sign_in      : registered data_in[31]
//   is_zero, is_inf, is_nan, is_snan, is_subnormal : input classification
module abs_value_ieee754 #(
  parameter bit CANON_NAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] data_in,
  input  logic [1:0]  op,
  output logic        out_valid,
  output logic [31:0] data_out,
  output logic        sign_in,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan,
  output logic        is_subnormal
);

  localparam logic [1:0] OP_ABS  = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_NABS = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_man_zero;
  logic        w_is_zero;
  logic        w_is_sub;
  logic        w_is_inf;
  logic        w_is_nan;
  logic        w_is_snan;
  logic        w_sign;
  logic [31:0] w_result;

  assign w_exp      = data_in[30:23];
  assign w_man      = data_in[22:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_ones = (w_exp == '1);
  assign w_man_zero = (w_man == '0);

  // Classes are mutually exclusive by construction (exp all-0 vs all-1).
  assign w_is_zero = w_exp_zero &  w_man_zero;
  assign w_is_sub  = w_exp_zero & ~w_man_zero;
  assign w_is_inf  = w_exp_ones &  w_man_zero;
  assign w_is_nan  = w_exp_ones & ~w_man_zero;
  assign w_is_snan = w_is_nan   & ~w_man[22];

  always_comb begin
    w_sign = data_in[31];
    case (op)
      OP_ABS:  w_sign = 1'b0;
      OP_NEG:  w_sign = ~data_in[31];
      OP_NABS: w_sign = 1'b1;
      OP_PASS: w_sign = data_in[31];
      default: w_sign = data_in[31];
    endcase
  end

  // Canonical NaN overrides the sign selection too, so it is op-independent.
  assign w_result = (CANON_NAN && w_is_nan) ? QNAN : {w_sign, data_in[30:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      data_out     <= '0;
      sign_in      <= 1'b0;
      is_zero      <= 1'b0;
      is_inf       <= 1'b0;
      is_nan       <= 1'b0;
      is_snan      <= 1'b0;
      is_subnormal <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out     <= w_result;
        sign_in      <= data_in[31];
        is_zero      <= w_is_zero;
        is_inf       <= w_is_inf;
        is_nan       <= w_is_nan;
        is_snan      <= w_is_snan;
        is_subnormal <= w_is_sub;
      end
    end
  end

endmodule

// File: tb/tb_abs_value_ieee754.sv
module tb_abs_value_ieee754;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] data_in;
  logic [1:0]  op;

  logic        out_valid0, sign_in0, z0, inf0, nan0, snan0, sub0;
  logic [31:0] data_out0;
  logic        out_valid1, sign_in1, z1, inf1, nan1, snan1, sub1;
  logic [31:0] data_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  abs_value_ieee754 #(.CANON_NAN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .op(op),
    .out_valid(out_valid0), .data_out(data_out0), .sign_in(sign_in0),
    .is_zero(z0), .is_inf(inf0), .is_nan(nan0), .is_snan(snan0),
    .is_subnormal(sub0)
  );

  abs_value_ieee754 #(.CANON_NAN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .op(op),
    .out_valid(out_valid1), .data_out(data_out1), .sign_in(sign_in1),
    .is_zero(z1), .is_inf(inf1), .is_nan(nan1), .is_snan(snan1),
    .is_subnormal(sub1)
  );

  // Observation: {out_valid, data_out, sign_in, zero, subnormal, inf, nan, snan}
  logic [38:0] w_obs0, w_obs1;
  assign w_obs0 = {out_valid0, data_out0, sign_in0, z0, sub0, inf0, nan0, snan0};
  assign w_obs1 = {out_valid1, data_out1, sign_in1, z1, sub1, inf1, nan1, snan1};

  // Drive one input cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [1:0] o,
                      input logic [31:0] d);
    rst = r; in_valid = v; op = o; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [38:0] e;
    // Valid input during reset must be discarded.
    step(1'b1, 1'b1, 2'b00, 32'hBF80_0000);
    step(1'b1, 1'b1, 2'b00, 32'hBF80_0000);
    e = '0;
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL reset_dut0 got %h expected %h", w_obs0, e); end
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL reset_dut1 got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b0, 2'b00, 32'h1234_5678);
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL reset_release got %h expected %h", w_obs0, e); end
  endtask

  task automatic test_normal_b2b();
    logic [38:0] e;
    step(1'b0, 1'b1, 2'b00, 32'h3F80_0000);
    e = {1'b1, 32'h3F80_0000, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL normal_pos got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b00, 32'hBF80_0000);
    e = {1'b1, 32'h3F80_0000, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL normal_neg got %h expected %h", w_obs0, e); end
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL normal_neg_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b0, 2'b00, 32'hBF80_0000);
    e = {1'b0, 32'h3F80_0000, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL normal_valid_drop got %h expected %h", w_obs0, e); end
  endtask

  task automatic test_ops();
    logic [38:0] e;
    step(1'b0, 1'b1, 2'b01, 32'h4049_0FDB);
    e = {1'b1, 32'hC049_0FDB, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL op_neg got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b10, 32'h4049_0FDB);
    e = {1'b1, 32'hC049_0FDB, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL op_nabs got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b11, 32'h4049_0FDB);
    e = {1'b1, 32'h4049_0FDB, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL op_pass got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b01, 32'hC049_0FDB);
    e = {1'b1, 32'h4049_0FDB, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL op_neg_of_neg got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b11, 32'hC049_0FDB);
    e = {1'b1, 32'hC049_0FDB, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL op_pass_neg got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b10, 32'hC049_0FDB);
    e = {1'b1, 32'hC049_0FDB, 1'b1, 5'b00000};
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL op_nabs_neg_canon got %h expected %h", w_obs1, e); end
  endtask

  task automatic test_specials();
    logic [38:0] e;
    step(1'b0, 1'b1, 2'b00, 32'hFF80_0000);
    e = {1'b1, 32'h7F80_0000, 1'b1, 5'b00100};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_inf got %h expected %h", w_obs0, e); end
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL spec_inf_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b1, 2'b00, 32'h8000_0000);
    e = {1'b1, 32'h0000_0000, 1'b1, 5'b10000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_zero got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b00, 32'h8000_0001);
    e = {1'b1, 32'h0000_0001, 1'b1, 5'b01000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_subnormal got %h expected %h", w_obs0, e); end
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL spec_subnormal_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b1, 2'b01, 32'h7F7F_FFFF);
    e = {1'b1, 32'hFF7F_FFFF, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_max_normal got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b10, 32'h0080_0000);
    e = {1'b1, 32'h8080_0000, 1'b0, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_min_normal got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b01, 32'h007F_FFFF);
    e = {1'b1, 32'h807F_FFFF, 1'b0, 5'b01000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_max_subnormal got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b10, 32'h7F80_0000);
    e = {1'b1, 32'hFF80_0000, 1'b0, 5'b00100};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL spec_nabs_inf got %h expected %h", w_obs0, e); end
  endtask

  task automatic test_nan();
    logic [38:0] e;
    step(1'b0, 1'b1, 2'b00, 32'hFFA0_0000);
    e = {1'b1, 32'h7FA0_0000, 1'b1, 5'b00011};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL nan_snan got %h expected %h", w_obs0, e); end
    e = {1'b1, 32'h7FC0_0000, 1'b1, 5'b00011};
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL nan_snan_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b1, 2'b00, 32'h7FC0_0001);
    e = {1'b1, 32'h7FC0_0001, 1'b0, 5'b00010};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL nan_qnan got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b10, 32'h7FC0_0001);
    e = {1'b1, 32'hFFC0_0001, 1'b0, 5'b00010};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL nan_qnan_nabs got %h expected %h", w_obs0, e); end
    e = {1'b1, 32'h7FC0_0000, 1'b0, 5'b00010};
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL nan_qnan_nabs_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b1, 2'b01, 32'hFF80_0001);
    e = {1'b1, 32'h7F80_0001, 1'b1, 5'b00011};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL nan_min_snan got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b11, 32'h7FFF_FFFF);
    e = {1'b1, 32'h7FFF_FFFF, 1'b0, 5'b00010};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL nan_all_ones got %h expected %h", w_obs0, e); end
    e = {1'b1, 32'h7FC0_0000, 1'b0, 5'b00010};
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL nan_all_ones_canon got %h expected %h", w_obs1, e); end
  endtask

  task automatic test_hold();
    logic [38:0] e;
    // Follows test_nan: last loaded operand was 7FFFFFFF with op pass.
    step(1'b0, 1'b0, 2'b10, 32'h0000_0000);
    e = {1'b0, 32'h7FFF_FFFF, 1'b0, 5'b00010};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL hold_1 got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b0, 2'b01, 32'h8000_0001);
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL hold_2 got %h expected %h", w_obs0, e); end
    e = {1'b0, 32'h7FC0_0000, 1'b0, 5'b00010};
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL hold_canon got %h expected %h", w_obs1, e); end
  endtask

  task automatic test_reset_mid_stream();
    logic [38:0] e;
    step(1'b0, 1'b1, 2'b00, 32'hC000_0000);
    e = {1'b1, 32'h4000_0000, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL rms_pre got %h expected %h", w_obs0, e); end
    step(1'b1, 1'b1, 2'b00, 32'hFF80_0000);
    e = '0;
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL rms_reset got %h expected %h", w_obs0, e); end
    checks++; if (w_obs1 !== e) begin errors++; $display("FAIL rms_reset_canon got %h expected %h", w_obs1, e); end
    step(1'b0, 1'b0, 2'b00, 32'h4040_0000);
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL rms_no_ghost got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b00, 32'hC040_0000);
    e = {1'b1, 32'h4040_0000, 1'b1, 5'b00000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL rms_first_after got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b1, 2'b01, 32'h0000_0000);
    e = {1'b1, 32'h8000_0000, 1'b0, 5'b10000};
    checks++; if (w_obs0 !== e) begin errors++; $display("FAIL rms_second_after got %h expected %h", w_obs0, e); end
    step(1'b0, 1'b0, 2'b00, 32'h0000_0000);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00; data_in = '0;
    test_reset();
    test_normal_b2b();
    test_ops();
    test_specials();
    test_nan();
    test_hold();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abs_value_ieee754.md
ABS_VALUE_IEEE754 -- requirements
Module: abs_value_ieee754

Interface
- REQ-001 SHALL have parameter CANON_NAN, default 0, meaning: when 1, every NaN result is replaced by the canonical quiet NaN 32'h7FC00000.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-004 SHALL have port in_valid, input, 1 bit: data_in and op are valid this cycle.
- REQ-005 SHALL have port data_in, input, 32 bits: IEEE-754 single-precision operand.
- REQ-006 SHALL have port op, input, 2 bits: 00 abs, 01 negate, 10 negative-abs, 11 pass-through.
- REQ-007 SHALL have port out_valid, output, 1 bit: data_out and the flags hold a new result.
- REQ-008 SHALL have port data_out, output, 32 bits: result word.
- REQ-009 SHALL have port sign_in, output, 1 bit: the registered copy of data_in[31].
- REQ-010 SHALL have ports is_zero, is_inf, is_nan, is_snan and is_subnormal, each output, 1 bit: classification of the input operand.

Function
- REQ-011 SHALL register all outputs, giving a latency of exactly 1 clock from an in_valid=1 sample to out_valid=1 with its result.
- REQ-012 SHALL set out_valid on each edge to the value of in_valid sampled at that edge; there is no backpressure.
- REQ-013 SHALL load data_out, sign_in and all flags only when in_valid=1, and otherwise hold their previous values.
- REQ-014 SHALL form the result sign from data_in[31] as follows: abs gives 0, negate gives the inverted sign, negative-abs gives 1, pass gives the unchanged sign.
- REQ-015 SHALL copy data_out[30:0] from data_in[30:0] unchanged when CANON_NAN=0, for every input class including NaN, inf, zero and subnormal.
- REQ-016 SHALL, when CANON_NAN=1 and the input is NaN, output 32'h7FC00000 regardless of op; with CANON_NAN=1, non-NaN inputs follow REQ-014/REQ-015.
- REQ-017 SHALL decode the input fields as exp = data_in[30:23] and man = data_in[22:0].
- REQ-018 SHALL set is_zero when exp=0 and man=0.
- REQ-019 SHALL set is_subnormal when exp=0 and man!=0.
- REQ-020 SHALL set is_inf when exp=FF and man=0.
- REQ-021 SHALL set is_nan when exp=FF and man!=0.
- REQ-022 SHALL set is_snan when is_nan=1 and man[22]=0.
- REQ-023 SHALL ensure at most one of is_zero, is_subnormal, is_inf and is_nan is 1, and all are 0 for normal numbers.
- REQ-024 SHALL take all flags from the input operand independent of op and CANON_NAN.
- REQ-025 SHALL raise no exceptions and perform no rounding; the operation is a pure bit manipulation.
- REQ-026 SHALL accept back-to-back inputs every cycle, producing one result per cycle.

Reset
- REQ-027 SHALL, when rst=1 at a rising edge, set out_valid, data_out, sign_in and all flags to 0 on that edge.
- REQ-028 SHALL give rst priority over in_valid; an input presented in a reset cycle is discarded, with no result after reset release.
- REQ-029 SHALL produce the first valid result one cycle after the first in_valid=1 sampled with rst=0.

Verification
- REQ-030 SHALL pass the normal-number scenario: op=00, data_in 3F800000 then BF800000 back-to-back -> data_out 3F800000 then 3F800000, one cycle later each, out_valid high for 2 cycles, sign_in 0 then 1, all class flags 0.
- REQ-031 SHALL pass the per-op scenario: data_in 40490FDB, op 01/10/11 -> data_out C0490FDB / C0490FDB / 40490FDB.
- REQ-032 SHALL pass the special-value scenario: op=00 with FF800000 -> 7F800000 and is_inf=1; with 80000000 -> 00000000 and is_zero=1; with 80000001 -> 00000001 and is_subnormal=1.
- REQ-033 SHALL pass the NaN scenario: op=00 with FFA00000 -> 7FA00000 and is_nan=is_snan=1 when CANON_NAN=0, and -> 7FC00000 when CANON_NAN=1; with 7FC00001 -> is_nan=1, is_snan=0.
- REQ-034 SHALL pass the hold scenario: after a result, in_valid=0 with data_in changed -> out_valid=0 and data_out and flags unchanged.
- REQ-035 SHALL pass the reset-mid-stream scenario: in_valid=1 streaming and rst=1 for one cycle -> all outputs 0 on the next edge; after release, the result appears one cycle after the next valid input.
